// File: rtl/controle_multiciclo.sv
// ---------------------------------------------------------------------------
// controle_multiciclo
// Multi-cycle control unit for the RISC-V datapath. Walks each instruction
// through FETCH / DECODE / EXEC / MEM / WB and drives the datapath strobes and
// ALU control. Memory accesses use a ready handshake guarded by a timeout;
// undefined opcodes and memory timeouts park the unit in TRAP until reset.
//
// Parameters
//   CNT_W        width of the retired-instruction counter (wraps)
//   MEM_TIMEOUT  cycles of memready=0 tolerated in FETCH/MEM (0 = forever)
//   ENABLE_ITYPE 1: ALU-immediate class (tipo 001) is legal
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   tipo, funct3, funct7b5 instruction fields (sampled in DECODE only)
//   aluzero, memready     datapath / memory status
//   pcwrite, pcsrc, irwrite, regiwrite, memread, memwrite, memtoreg,
//   alusrc, aluop, alucontrol   datapath control
//   estado                current state encoding
//   illegal, buserr       sticky trap causes
//   instcount             retired-instruction count
//
// state  | meaning
// -------+--------------------------------------------------------------
// FETCH  | read instruction memory, load IR and PC+4 on memready
// DECODE | latch instruction fields, check legality
// EXEC   | ALU operation; beq resolves and retires here
// MEM    | data memory access, held until memready (sw retires here)
// WB     | register file write, retire
// TRAP   | illegal op or memory timeout; strobes off until reset
// ---------------------------------------------------------------------------
module controle_multiciclo #(
    parameter int CNT_W        = 32,
    parameter int MEM_TIMEOUT  = 16,
    parameter bit ENABLE_ITYPE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       tipo,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             aluzero,
    input  logic             memready,
    output logic             pcwrite,
    output logic             pcsrc,
    output logic             irwrite,
    output logic             regiwrite,
    output logic             memread,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             alusrc,
    output logic [1:0]       aluop,
    output logic [3:0]       alucontrol,
    output logic [2:0]       estado,
    output logic             illegal,
    output logic             buserr,
    output logic [CNT_W-1:0] instcount
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_TRAP   = 3'b111
    } state_t;

    localparam logic [2:0] T_LW   = 3'b000;
    localparam logic [2:0] T_ALUI = 3'b001;
    localparam logic [2:0] T_SW   = 3'b010;
    localparam logic [2:0] T_R    = 3'b011;
    localparam logic [2:0] T_BEQ  = 3'b110;

    // Counter only needs to reach MEM_TIMEOUT-1: the trap fires on the
    // cycle that would have made it MEM_TIMEOUT.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_t            state, state_next;
    logic [2:0]        tipo_q, funct3_q;
    logic              funct7b5_q;
    logic [WAIT_W-1:0] waitcnt;

    logic pcwrite_c, pcsrc_c, irwrite_c, regiwrite_c;
    logic memread_c, memwrite_c, memtoreg_c;
    logic latch_ir, retire, set_illegal, set_buserr, wait_tmo;

    function automatic logic is_legal(input logic [2:0] t, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (t)
            T_LW, T_SW, T_BEQ: ok = 1'b1;
            T_R:               ok = (f3 != 3'b010) && (f3 != 3'b011);
            T_ALUI:            ok = ENABLE_ITYPE && (f3 != 3'b010) && (f3 != 3'b011);
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] funct_decode(input logic [2:0] f3, input logic sub);
        logic [3:0] c;
        c = 4'b0010;
        case (f3)
            3'b000:  c = sub ? 4'b0110 : 4'b0010;
            3'b001:  c = 4'b0100;
            3'b100:  c = 4'b0011;
            3'b101:  c = 4'b0101;
            3'b110:  c = 4'b0001;
            3'b111:  c = 4'b0000;
            default: c = 4'b0010;
        endcase
        return c;
    endfunction

    assign wait_tmo = (MEM_TIMEOUT != 0) && !memready && (waitcnt == WAIT_LAST);

    always_comb begin
        state_next  = state;
        pcwrite_c   = 1'b0;
        pcsrc_c     = 1'b0;
        irwrite_c   = 1'b0;
        regiwrite_c = 1'b0;
        memread_c   = 1'b0;
        memwrite_c  = 1'b0;
        memtoreg_c  = 1'b0;
        alusrc      = 1'b0;
        aluop       = 2'b00;
        latch_ir    = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_buserr  = 1'b0;

        case (state)
            S_FETCH: begin
                memread_c = 1'b1;
                if (memready) begin
                    irwrite_c  = 1'b1;
                    pcwrite_c  = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_tmo) begin
                    set_buserr = 1'b1;
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                latch_ir = 1'b1;
                if (is_legal(tipo, funct3)) begin
                    state_next = S_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    state_next  = S_TRAP;
                end
            end
            S_EXEC: begin
                case (tipo_q)
                    T_LW, T_SW: begin
                        alusrc     = 1'b1;
                        state_next = S_MEM;
                    end
                    T_R: begin
                        aluop      = 2'b10;
                        state_next = S_WB;
                    end
                    T_ALUI: begin
                        alusrc     = 1'b1;
                        aluop      = 2'b10;
                        state_next = S_WB;
                    end
                    T_BEQ: begin
                        aluop      = 2'b01;
                        pcsrc_c    = 1'b1;
                        pcwrite_c  = aluzero;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: begin
                        set_illegal = 1'b1;
                        state_next  = S_TRAP;
                    end
                endcase
            end
            S_MEM: begin
                alusrc = 1'b1;
                if (tipo_q == T_LW) begin
                    memread_c = 1'b1;
                end else begin
                    memwrite_c = 1'b1;
                end
                if (memready) begin
                    if (tipo_q == T_LW) begin
                        state_next = S_WB;
                    end else begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                end else if (wait_tmo) begin
                    set_buserr = 1'b1;
                    state_next = S_TRAP;
                end
            end
            S_WB: begin
                regiwrite_c = 1'b1;
                if (tipo_q == T_LW) begin
                    memtoreg_c = 1'b1;
                    alusrc     = 1'b1;
                end else begin
                    // keep the ALU result stable while it is written back
                    alusrc = (tipo_q == T_ALUI);
                    aluop  = 2'b10;
                end
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    always_comb begin
        case (aluop)
            2'b01:   alucontrol = 4'b0110;
            2'b10:   alucontrol = funct_decode(funct3_q, funct7b5_q && (tipo_q == T_R));
            default: alucontrol = 4'b0010;
        endcase
    end

    // Strobes are gated by reset so an aborted instruction has no side effects.
    assign pcwrite   = pcwrite_c   && !reset;
    assign pcsrc     = pcsrc_c     && !reset;
    assign irwrite   = irwrite_c   && !reset;
    assign regiwrite = regiwrite_c && !reset;
    assign memread   = memread_c   && !reset;
    assign memwrite  = memwrite_c  && !reset;
    assign memtoreg  = memtoreg_c  && !reset;
    assign estado    = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            tipo_q     <= 3'b000;
            funct3_q   <= 3'b000;
            funct7b5_q <= 1'b0;
            waitcnt    <= '0;
            instcount  <= '0;
            illegal    <= 1'b0;
            buserr     <= 1'b0;
        end else begin
            state <= state_next;
            if (latch_ir) begin
                tipo_q     <= tipo;
                funct3_q   <= funct3;
                funct7b5_q <= funct7b5;
            end
            if (retire) begin
                instcount <= instcount + CNT_W'(1);
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_buserr) begin
                buserr <= 1'b1;
            end
            if (state_next != state) begin
                waitcnt <= '0;
            end else if ((state == S_FETCH || state == S_MEM) && !memready &&
                         (MEM_TIMEOUT != 0) && (waitcnt != WAIT_LAST)) begin
                waitcnt <= waitcnt + WAIT_W'(1);
            end
        end
    end

endmodule
